// File: rtl/hex_entry_pad.sv
// hex_entry_pad: debounced pushbutton front end for 4-digit hexadecimal entry.
// Four raw buttons (up, left, enter, clr) are synchronized and debounced.
// Each debounced press edits a live 16-bit value and a digit cursor.
// ENTER commits the value to downstream logic over a valid/ready handshake.
// Optional feature: define HEX_ENTRY_AUTOREPEAT_EN to make a held up button
// repeat every 2^RPT_BITS cycles. The default build has no repeat logic.
module hex_entry_pad #(
  parameter int DB_BITS  = 18,
  parameter int RPT_BITS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_left,
  input  logic        btn_enter,
  input  logic        btn_clr,
  output logic [15:0] edit_val,
  output logic [1:0]  cursor,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy
);

  // Reject parameter values for which the counters make no sense.
  if (DB_BITS < 2 || RPT_BITS < 2) begin : g_bad_params
    $error("hex_entry_pad: DB_BITS and RPT_BITS must both be at least 2");
  end

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [DB_BITS-1:0] DB_MAX = '1;

  // Button bit positions: 0 = up, 1 = left, 2 = enter, 3 = clr.
  logic [3:0] btn_raw;
  logic [3:0] press_evt;

  assign btn_raw = {btn_clr, btn_enter, btn_left, btn_up};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_btn
    logic                sync1_q;
    logic                sync2_q;
    logic                prev_q;
    logic                stable_q;
    logic                press_q;
    logic [DB_BITS-1:0]  cnt_q;

    // Synchronize, debounce and detect the rising edge of the stable level.
    // The stable level only moves once the synchronized input has held one
    // value for a complete window. The same-as-last-cycle test stops a change
    // from slipping through on the edge where the counter is cleared.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        prev_q   <= 1'b0;
        stable_q <= 1'b0;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
        if (sync2_q != prev_q) begin
          cnt_q <= '0;
        end else if (cnt_q != DB_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
        press_q <= 1'b0;
        if ((cnt_q == DB_MAX) && (sync2_q == prev_q) && (sync2_q != stable_q)) begin
          stable_q <= sync2_q;
          press_q  <= sync2_q;
        end
      end
    end

    assign press_evt[gi] = press_q;
  end

  state_t       state_q,      state_d;
  logic [15:0]  edit_val_q,   edit_val_d;
  logic [1:0]   cursor_q,     cursor_d;
  logic [15:0]  data_out_q,   data_out_d;
  logic         data_valid_q, data_valid_d;
  logic         up_evt;

`ifdef HEX_ENTRY_AUTOREPEAT_EN
  localparam logic [RPT_BITS-1:0] RPT_MAX = '1;

  logic [RPT_BITS-1:0] rpt_q, rpt_d;
  logic                stable_up;
  logic                rpt_fire;

  assign stable_up = g_btn[0].stable_q;
  assign rpt_fire  = (state_q == ST_EDIT) && stable_up && (rpt_q == RPT_MAX);
  assign up_evt    = press_evt[0] | rpt_fire;

  // Repeat timer: runs while up is held in EDIT. It restarts on any press
  // event, on release and in PEND. It wraps to zero on the cycle it fires.
  always_comb begin
    rpt_d = rpt_q + 1'b1;
    if ((state_q != ST_EDIT) || !stable_up || (|press_evt)) begin
      rpt_d = '0;
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign up_evt = press_evt[0];
`endif

  // Next-state logic. In EDIT only the highest-priority event is acted on.
  // In PEND every press is discarded until the handshake completes.
  always_comb begin
    state_d      = state_q;
    edit_val_d   = edit_val_q;
    cursor_d     = cursor_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    case (state_q)
      ST_EDIT: begin
        if (press_evt[3]) begin
          edit_val_d = '0;
          cursor_d   = '0;
        end else if (press_evt[2]) begin
          data_out_d   = edit_val_q;
          data_valid_d = 1'b1;
          state_d      = ST_PEND;
        end else if (press_evt[1]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (up_evt) begin
          // Per-nibble increment: 4-bit arithmetic wraps F to 0 with no carry.
          edit_val_d[{cursor_q, 2'b00} +: 4] = edit_val_q[{cursor_q, 2'b00} +: 4] + 4'd1;
        end
      end
      ST_PEND: begin
        if (data_valid_q && data_ready) begin
          data_valid_d = 1'b0;
          state_d      = ST_EDIT;
        end
      end
      default: begin
        state_d = ST_EDIT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EDIT;
      edit_val_q   <= '0;
      cursor_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_val_q   <= edit_val_d;
      cursor_q     <= cursor_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign edit_val   = edit_val_q;
  assign cursor     = cursor_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = data_valid_q;

endmodule
